// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read / 1-write register file with a
// built-in clear sequencer. The storage array has no reset. After reset, or
// on clear_req, a sweep writes zero to every entry, and busy masks the read
// ports until the sweep completes.
//
// Parameters:
//   XLEN     data width in bits
//   DEPTH    number of entries (power of two, >= 2)
//   ZERO_REG 1 = entry 0 reads as zero and ignores writes
//   BYPASS   1 = a read of the entry being written returns dataIn in the same cycle
//   AW       address width (derived from DEPTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (starts a sweep)
//   clear_req  single-cycle request to re-zero the file (ignored mid-sweep)
//   regWrite   write enable
//   Addr1      read port 1 address
//   Addr2      read port 2 address
//   Addr3      write address
//   dataIn     write data
//   baseAddr   read port 1 data
//   writeData  read port 2 data
//   busy       high while a clear sweep is in progress
module regfile_param #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_req,
  input  logic            regWrite,
  input  logic [AW-1:0]   Addr1,
  input  logic [AW-1:0]   Addr2,
  input  logic [AW-1:0]   Addr3,
  input  logic [XLEN-1:0] dataIn,
  output logic [XLEN-1:0] baseAddr,
  output logic [XLEN-1:0] writeData,
  output logic            busy
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx, clr_idx_nxt;
  logic [XLEN-1:0] mem [DEPTH];
  logic            wr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        if (clr_idx == AW'(DEPTH - 1)) begin
          state_nxt   = READY;
          clr_idx_nxt = '0;
        end else begin
          clr_idx_nxt = clr_idx + AW'(1);
        end
      end
      READY: begin
        if (clear_req) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_idx_nxt = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_ok = regWrite && !busy && !(ZERO_REG && (Addr3 == '0));

  // A single write port keeps the array RAM-inferable. The sweep and normal
  // writes are mutually exclusive because both depend on busy.
  always_ff @(posedge clk) begin
    if (busy)
      mem[clr_idx] <= '0;
    else if (wr_ok)
      mem[Addr3] <= dataIn;
  end

  // The overrides are applied from lowest to highest priority, so busy wins
  // over the zero register, and the zero register wins over the bypass.
  always_comb begin
    baseAddr = mem[Addr1];
    if (BYPASS && wr_ok && (Addr1 == Addr3)) baseAddr = dataIn;
    if (ZERO_REG && (Addr1 == '0))           baseAddr = '0;
    if (busy)                                baseAddr = '0;
  end

  always_comb begin
    writeData = mem[Addr2];
    if (BYPASS && wr_ok && (Addr2 == Addr3)) writeData = dataIn;
    if (ZERO_REG && (Addr2 == '0))           writeData = '0;
    if (busy)                                writeData = '0;
  end

endmodule
